// File: rtl/hazard_fwd_ctrl.sv
// EX-stage operand forwarding selects plus load-use stall / taken-branch flush sequencing.
// Optional HAZARD_PERF_CNT_EN builds 32-bit stall/flush cycle counters.

// Per-source forward select: EX/MEM hit wins over MEM/WB, x0 never forwarded.
module hazard_fwd_lane #(
    parameter int REG_AW = 5
) (
    input  logic              uses,
    input  logic [REG_AW-1:0] src,
    input  logic              ex_rw,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_rw,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        sel,
    output logic              hit_ex
);
    logic live, hit_mem;

    assign live    = uses & (src != '0);
    assign hit_ex  = live & ex_rw & (ex_rd == src);
    assign hit_mem = live & mem_rw & (mem_rd == src);
    assign sel     = hit_ex ? 2'b10 : (hit_mem ? 2'b01 : 2'b00);
endmodule

module hazard_fwd_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_AW       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count
);
    localparam int NUM_SRC = 2;
    localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

    typedef struct packed {
        logic              rw;
        logic              mr;
        logic [REG_AW-1:0] rd;
    } slot_t;

    state_t state, state_nx;
    logic [1:0] cnt, cnt_nx;
    slot_t ex_q, mem_q, id_slot;

    logic [NUM_SRC-1:0][REG_AW-1:0] srcs;
    logic [NUM_SRC-1:0]             uses;
    logic [NUM_SRC-1:0][1:0]        sel;
    logic [NUM_SRC-1:0]             hit_ex;
    logic [NUM_SRC-1:0][1:0]        sel_q;

    logic load_use, stall_c, bubble_c, flush_c, enter;

    assign srcs    = {id_rs2, id_rs1};
    assign uses    = {id_uses_rs2, id_uses_rs1};
    assign id_slot = '{rw: id_reg_write, mr: id_mem_read, rd: id_rd};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_fwd_lane #(.REG_AW(REG_AW)) u_lane (
            .uses   (uses[i]),
            .src    (srcs[i]),
            .ex_rw  (ex_q.rw),
            .ex_rd  (ex_q.rd),
            .mem_rw (mem_q.rw),
            .mem_rd (mem_q.rd),
            .sel    (sel[i]),
            .hit_ex (hit_ex[i])
        );
    end

    // A source hit on EX already implies ex_rd != 0 and ex_rw.
    assign load_use = id_valid & ex_q.mr & (|hit_ex);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_c  = 1'b1;
                    cnt_nx   = CNT_INIT;
                    state_nx = FLUSH;
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    state_nx = LU_STALL;
                end
            end
            LU_STALL: begin
                // Load has moved to MEM; the held instruction now takes the MEM/WB path.
                if (ex_branch_taken) begin
                    flush_c  = 1'b1;
                    cnt_nx   = CNT_INIT;
                    state_nx = FLUSH;
                end else if (load_use) begin
                    state_nx = LU_STALL;
                end else begin
                    state_nx = RUN;
                end
            end
            FLUSH: begin
                if (cnt != 2'd0) begin
                    flush_c = 1'b1;
                    cnt_nx  = cnt - 2'd1;
                end else begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Outputs are forced low while reset is held so they clear asynchronously.
    assign stall        = reset_n & stall_c;
    assign bubble_id_ex = reset_n & bubble_c;
    assign flush_if_id  = reset_n & flush_c;
    assign flush_id_ex  = reset_n & flush_c;
    assign enter        = id_valid & ~stall_c & ~flush_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= 2'd0;
            ex_q  <= '0;
            mem_q <= '0;
            sel_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            mem_q <= ex_q;
            ex_q  <= enter ? id_slot : '0;
            sel_q <= enter ? sel : '0;
        end
    end

    assign fwd_a_sel = sel_q[0];
    assign fwd_b_sel = sel_q[1];

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_c) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_c) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed + random check of hazard_fwd_ctrl against a slot-level pipeline model.
module tb_hazard_fwd_ctrl;
    localparam int FC = 2;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, ex_branch_taken;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall, bubble_id_ex, flush_if_id, flush_id_ex;
    logic [31:0]   stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    // Model: what each pipeline slot holds, and how many flush cycles remain.
    bit m_ex_rw, m_ex_mr, m_mem_rw;
    int m_ex_rd, m_mem_rd;
    logic [1:0] m_fa, m_fb;
    bit m_after_stall, m_in_flush;
    int m_flush_rem;
    int m_sc, m_fc;

    hazard_fwd_ctrl #(.FLUSH_CYCLES(FC), .REG_AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_sel(input bit u, input int s);
        if (u && s != 0 && m_ex_rw && m_ex_rd == s) return 2'b10;
        if (u && s != 0 && m_mem_rw && m_mem_rd == s) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] perf_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v - v);
`endif
    endfunction

    task automatic model_reset();
        m_ex_rw = 0; m_ex_mr = 0; m_mem_rw = 0; m_ex_rd = 0; m_mem_rd = 0;
        m_fa = 0; m_fb = 0; m_after_stall = 0; m_in_flush = 0; m_flush_rem = 0;
        m_sc = 0; m_fc = 0;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fa"}, 32'(fwd_a_sel), 0);
        chk({tag, "_fb"}, 32'(fwd_b_sel), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_bub"}, 32'(bubble_id_ex), 0);
        chk({tag, "_fif"}, 32'(flush_if_id), 0);
        chk({tag, "_fex"}, 32'(flush_id_ex), 0);
        chk({tag, "_sc"}, stall_count, 0);
        chk({tag, "_fc"}, flush_count, 0);
    endtask

    // One ID-stage cycle: drive at negedge, check, then advance the model past the next posedge.
    task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit rw, input bit mr, input bit br);
        bit lu, fl, st, enter;
        @(negedge clk);
        if (m_in_flush || m_after_stall) br = 0;
        id_valid = v; id_rs1 = AW'(r1); id_uses_rs1 = u1; id_rs2 = AW'(r2); id_uses_rs2 = u2;
        id_rd = AW'(rd); id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
        #1;
        lu = v && m_ex_mr && m_ex_rw && m_ex_rd != 0 &&
             ((u1 && r1 == m_ex_rd) || (u2 && r2 == m_ex_rd));
        if (m_in_flush) begin
            fl = (m_flush_rem > 0); st = 0;
        end else if (m_after_stall) begin
            fl = 0; st = 0;
        end else begin
            fl = br; st = !br && lu;
        end
        chk("stall", 32'(stall), 32'(st));
        chk("bubble", 32'(bubble_id_ex), 32'(st));
        chk("flush_if_id", 32'(flush_if_id), 32'(fl));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(fl));
        chk("fwd_a", 32'(fwd_a_sel), 32'(m_fa));
        chk("fwd_b", 32'(fwd_b_sel), 32'(m_fb));
        chk("stall_count", stall_count, perf_exp(m_sc));
        chk("flush_count", flush_count, perf_exp(m_fc));
        enter = v && !st && !fl;
        m_fa = enter ? ref_sel(u1, r1) : 2'b00;
        m_fb = enter ? ref_sel(u2, r2) : 2'b00;
        m_mem_rw = m_ex_rw; m_mem_rd = m_ex_rd;
        m_ex_rw = enter && rw; m_ex_mr = enter && mr; m_ex_rd = enter ? rd : 0;
        m_sc += int'(st); m_fc += int'(fl);
        if (m_in_flush) begin
            if (m_flush_rem > 0) m_flush_rem--;
            else m_in_flush = 0;
        end else if (fl) begin
            m_in_flush = 1; m_flush_rem = FC - 1;
        end
        m_after_stall = st;
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset_n = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1;

        // ALU chain: back-to-back gives EX/MEM, one gap gives MEM/WB
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 0);
        nop();
        chk("chain_ex_fa", 32'(fwd_a_sel), 2);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 1, 1, 2, 1, 9, 1, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 0, 0);
        nop();
        chk("chain_mem_fa", 32'(fwd_a_sel), 1);

        // x5 in both EX and MEM: EX priority on both operands
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 5, 1, 5, 1, 8, 1, 0, 0);
        nop();
        chk("both_fa", 32'(fwd_a_sel), 2);
        chk("both_fb", 32'(fwd_b_sel), 2);

        // load-use: one stall cycle then MEM/WB forward
        step(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(1, 1, 1, 7, 1, 8, 1, 0, 0);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble_id_ex), 1);
        step(1, 1, 1, 7, 1, 8, 1, 0, 0);
        chk("lu_stall_off", 32'(stall), 0);
        nop();
        chk("lu_fb", 32'(fwd_b_sel), 1);

        // x0 writes are never forwarded
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 1, 0, 1, 4, 1, 0, 0);
        chk("x0_stall", 32'(stall), 0);
        nop();
        chk("x0_fa", 32'(fwd_a_sel), 0);

        // taken branch: FC flush cycles
        step(1, 0, 0, 0, 0, 3, 1, 0, 1);
        chk("br_flush0", 32'(flush_id_ex), 1);
        nop();
        chk("br_flush1", 32'(flush_if_id), 1);
        nop();
        chk("br_flush_end", 32'(flush_id_ex), 0);
        nop();

        // branch coincident with load-use: flush wins
        step(1, 0, 0, 0, 0, 7, 1, 1, 0);
        step(1, 7, 1, 0, 0, 8, 1, 0, 1);
        chk("brlu_stall", 32'(stall), 0);
        chk("brlu_flush", 32'(flush_id_ex), 1);
        repeat (3) nop();

        // randomized traffic over a small register set to force hits
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 9) == 0));
        end
        repeat (4) nop();

        // async reset in the middle of a flush
        step(1, 0, 0, 0, 0, 2, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_flush_on", 32'(flush_id_ex), 1);
        ex_branch_taken = 1;
        reset_n = 0;
        #1;
        check_all_zero("rst_mid_flush");
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
        nop();
        check_all_zero("post_reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_reset_flush", 32'(flush_if_id), 1);
        repeat (3) nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline-hazard controller that drives the select inputs of the two EX-stage 3:1 operand muxes (ALU operand A/B forwarding). It sits between ID and EX. It shadows destination-register info for the EX and MEM stages and registers forwarding selects into EX. It also sequences load-use stalls and branch-taken flushes with a small FSM.

Parameters:
FLUSH_CYCLES, 1, cycles flush_if_id/flush_id_ex stay asserted after a taken branch; legal range 1..3.
REG_AW, 5, register-index width.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  async active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source 1 index
id_rs2  in  REG_AW  ID source 2 index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  ID destination index
id_reg_write  in  1  ID instruction writes rd
id_mem_read  in  1  ID instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
fwd_a_sel  out  2  operand-A mux select during EX: 00 regfile, 01 MEM/WB, 10 EX/MEM
fwd_b_sel  out  2  operand-B mux select, same encoding
stall  out  1  hold PC and IF/ID
bubble_id_ex  out  1  insert NOP into ID/EX
flush_if_id  out  1  squash IF/ID
flush_id_ex  out  1  squash ID/EX
stall_count  out  32  load-use stall cycles (feature)
flush_count  out  32  flush cycles (feature)

Behaviour:
- Reset (reset_n=0, async): all outputs 0; FSM=RUN; shadow regs cleared (ex_rw=ex_mr=mem_rw=0, rd=0); flush counter 0.
- Shadow tracking per clock: MEM slot <= EX slot; EX slot <= ID info if id_valid and no stall/flush, else bubble (rw=0, mr=0, rd=0).
- Forward select, combinational on ID inputs and shadow, registered on the same edge the instruction enters EX. Per source s:
  - 10 if uses_s, s!=0, ex_rw, ex_rd==s.
  - Else 01 if uses_s, s!=0, mem_rw, mem_rd==s.
  - Else 00.
  - EX/MEM wins over MEM/WB. x0 is never forwarded.
  - The registered sel is 00 whenever a bubble enters EX.
- Load-use hazard: id_valid and ex_mr and ex_rw and ex_rd!=0 and ex_rd matches a used source.
- The WB-stage writer is covered by regfile write-through, outside this block.
- FSM:
  - RUN:
    - ex_branch_taken → FLUSH. Same cycle: flush_if_id=flush_id_ex=1, counter=FLUSH_CYCLES-1.
    - Else load-use → LU_STALL. Same cycle: stall=1, bubble_id_ex=1.
    - Else stay in RUN.
  - LU_STALL: lasts exactly one cycle. Combinational outputs are 0; the load is now in MEM, so the recomputed select is 01. Transitions:
    - ex_branch_taken → FLUSH.
    - Else a new load-use → LU_STALL again (back-to-back loads).
    - Else → RUN.
  - FLUSH: flush_if_id=flush_id_ex=1 while counter>0, decrementing each cycle. Counter==0 → RUN.
- stall, bubble_id_ex, flush_* are combinational from FSM state and current inputs; fwd_*_sel are registered.
- Simultaneous events: a branch overrides load-use. Flush deasserts stall, and the ID instruction is discarded rather than stalled.
- reset_n mid-stall or mid-flush: immediate return to RUN with all outputs 0; the counter restarts on the next branch.
- id_valid=0: no hazard and no forwarding; the bubble propagates.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_count increments each cycle stall=1; flush_count increments each cycle flush_id_ex=1. Both 32-bit wrap-around and cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ALU chain, sequence unchanged across EX→MEM: add x5 then sub using rs1=x5 in the next cycle → fwd_a_sel=10 during sub's EX, no stall. With one independent instr between them → fwd_a_sel=01.
- Both sources match, x5 in EX and x5 in MEM: rs1=rs2=x5 → fwd_a_sel=fwd_b_sel=10 (EX priority).
- ld x7 followed by add rs2=x7 → stall=1 and bubble_id_ex=1 for exactly 1 cycle, then fwd_b_sel=10→01 transition yields 01 in add's EX. stall_count=1 with macro.
- Write to x0 (rd=0, reg_write=1), then reader of x0 → fwd sel 00, no stall.
- FLUSH_CYCLES=2, ex_branch_taken pulse → flush_if_id/flush_id_ex high for 2 cycles. Branch coincident with load-use → stall stays 0, flush wins.
- Assert reset_n=0 during the FLUSH state → all outputs 0 asynchronously. After release: FSM=RUN, counters 0.
